alles_test_core: RTL and testbench

ALLES_TEST_CORE -- requirements
Module: alles_test

---
 rtl/alles_test_core.sv | 165 ++++++++++++++++
 tb/tb_alles_test_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alles_test_core.sv
// SPI flash command engine: WRITE_CMD / RD_STATUS / WR_DATA / RD_DATA frames, SCK = clk/4, mode 0.
// Optional macro ADDR_AUTOINC_EN: the 24-bit address advances after each completed WR_DATA or RD_DATA.
module alles_test_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] controll,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] status,
    output logic [7:0] rd_data
);
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 24;
    localparam int FRAME_W = 40;

    localparam logic [2:0] CMD_WRITE     = 3'b001;
    localparam logic [2:0] CMD_RD_STATUS = 3'b010;
    localparam logic [2:0] CMD_WR_DATA   = 3'b011;
    localparam logic [2:0] CMD_RD_DATA   = 3'b100;

    typedef enum logic [2:0] {S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_DONE} state_t;

    state_t              state, state_nxt;
    logic                en_q;
    logic                armed;
    logic                launch;
    logic                last_bit;
    logic [2:0]          cmd;
    logic [1:0]          phase;
    logic [5:0]          bit_cnt;
    logic [5:0]          nbits;
    logic [FRAME_W-1:0]  tx;
    logic [DATA_W-1:0]   rx;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   addr;

    function automatic logic valid_cmd(input logic [2:0] c);
        return (c >= CMD_WRITE) && (c <= CMD_RD_DATA);
    endfunction

    function automatic logic [5:0] frame_bits(input logic [2:0] c);
        case (c)
            CMD_WRITE:     return 6'd8;
            CMD_RD_STATUS: return 6'd16;
            default:       return 6'd40;
        endcase
    endfunction

    // Frames are left-aligned so the MSB always drives MOSI; read bits shift out zeros.
    function automatic logic [FRAME_W-1:0] frame_word(input logic [2:0] c,
                                                      input logic [ADDR_W-1:0] a,
                                                      input logic [DATA_W-1:0] d);
        case (c)
            CMD_WRITE:     return {8'h06, 32'h0};
            CMD_RD_STATUS: return {8'h05, 32'h0};
            CMD_WR_DATA:   return {8'h02, a, d};
            default:       return {8'h03, a, 8'h00};
        endcase
    endfunction

    // armed blocks a launch after reset until enable has been seen low.
    assign launch   = (state == S_IDLE) && enable && !en_q && armed && valid_cmd(controll);
    assign last_bit = (phase == 2'd3) && (bit_cnt == nbits - 6'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        spi_cs_n  = 1'b0;
        spi_sck   = 1'b0;
        spi_mosi  = 1'b0;
        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                spi_cs_n = 1'b1;
                if (launch) state_nxt = S_CS_SETUP;
            end
            S_CS_SETUP: state_nxt = S_SHIFT;
            S_SHIFT: begin
                spi_sck  = phase[1];
                spi_mosi = tx[FRAME_W-1];
                if (last_bit) state_nxt = S_CS_HOLD;
            end
            S_CS_HOLD: begin
                if (phase == 2'd3) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                spi_cs_n  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                spi_cs_n  = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q    <= 1'b0;
            armed   <= 1'b0;
            cmd     <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            nbits   <= '0;
            tx      <= '0;
            rx      <= '0;
            status  <= '0;
            rd_data <= '0;
            wr_data <= '0;
            addr    <= '0;
        end else begin
            en_q <= enable;
            if (!enable) armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    phase   <= '0;
                    bit_cnt <= '0;
                    if (launch) begin
                        cmd   <= controll;
                        nbits <= frame_bits(controll);
                        tx    <= frame_word(controll, addr, wr_data);
                    end
                end
                S_SHIFT: begin
                    phase <= phase + 2'd1;
                    // MISO captured as SCK rises (entry to phase 2); only the last 8 bits survive.
                    if (phase == 2'd1) rx <= {rx[DATA_W-2:0], spi_miso};
                    if (phase == 2'd3) begin
                        tx      <= {tx[FRAME_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                S_CS_HOLD: phase <= phase + 2'd1;
                S_DONE: begin
                    if (cmd == CMD_RD_STATUS) status  <= rx;
                    if (cmd == CMD_RD_DATA)   rd_data <= rx;
                    if (cmd == CMD_WR_DATA)   wr_data <= wr_data + 8'd1;
`ifdef ADDR_AUTOINC_EN
                    if (cmd == CMD_WR_DATA || cmd == CMD_RD_DATA) addr <= addr + 24'd1;
`else
                    addr <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alles_test_core.sv
// Bench for alles_test_core: table of SPI transactions with a frame scoreboard, plus
// hand sequences for held/busy enable edges, reserved codes and mid-frame reset.
`timescale 1ns/1ps
module tb_alles_test_core;
    localparam logic [2:0] C_WRITE = 3'b001;
    localparam logic [2:0] C_RDSR  = 3'b010;
    localparam logic [2:0] C_WR    = 3'b011;
    localparam logic [2:0] C_RD    = 3'b100;

`ifdef ADDR_AUTOINC_EN
    localparam logic [23:0] A1 = 24'd1, A2 = 24'd2, A3 = 24'd3, A_END = 24'd4;
`else
    localparam logic [23:0] A1 = 24'd0, A2 = 24'd0, A3 = 24'd0, A_END = 24'd0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] controll = 3'b000;
    logic       spi_miso;
    logic       spi_cs_n, spi_sck, spi_mosi, busy, done;
    logic [7:0] status, rd_data;

    alles_test_core dut (
        .clk(clk), .rst(rst), .enable(enable), .controll(controll), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .busy(busy), .done(done), .status(status), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cmd;
        logic [7:0]  resp;
        int          hold;
        logic [39:0] frame;
        int          nbits;
        logic [7:0]  exp_status;
        logic [7:0]  exp_rd;
    } vec_t;

    typedef struct {
        logic [39:0] frame;
        int          nbits;
        logic [7:0]  exp_status;
        logic [7:0]  exp_rd;
    } exp_t;

    exp_t        sb[$];
    exp_t        pend_e;
    bit          pend = 1'b0;
    vec_t        tv[8];
    int          pass_cnt = 0, total_cnt = 0;
    int          done_cnt = 0, cs_falls = 0, busy_len = 0, sck_n = 0, frame_len = 8;
    logic [39:0] cap = '0;
    logic [39:0] miso_pat = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Flash model: the response byte occupies the last 8 bit slots of the frame.
    always_comb begin
        spi_miso = 1'b0;
        if (sck_n < frame_len) spi_miso = miso_pat[frame_len - 1 - sck_n];
    end

    always @(posedge spi_sck or negedge spi_cs_n) begin
        if (!spi_sck) begin
            cap = '0;
            sck_n = 0;
            cs_falls++;
        end else begin
            cap = {cap[38:0], spi_mosi};
            sck_n++;
        end
    end

    always @(negedge clk) begin
        if (pend) begin
            check("status", status, pend_e.exp_status);
            check("rd_data", rd_data, pend_e.exp_rd);
            pend = 1'b0;
        end
        if (busy === 1'b1) busy_len++;
        else busy_len = 0;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got a done pulse, required none (no transaction pending)");
            end else begin
                pend_e = sb.pop_front();
                check("mosi_frame", cap, pend_e.frame);
                check("sck_pulses", sck_n, pend_e.nbits);
                check("busy_len", busy_len, 6 + 4 * pend_e.nbits);
                pend = 1'b1;
            end
        end
    end

    task automatic launch(input logic [2:0] c, input logic [7:0] r, input int n, input int hold);
        @(posedge clk);
        #1;
        controll  = c;
        frame_len = n;
        miso_pat  = {32'h0, r};
        enable    = 1'b1;
        repeat (hold) @(posedge clk);
        #1 enable = 1'b0;
    endtask

    task automatic wait_done(input string name, input int start);
        int i = 0;
        while (done_cnt == start && i < 1000) begin
            @(posedge clk);
            i++;
        end
        check(name, done_cnt, start + 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        int cs0;

        tv[0] = '{C_WRITE, 8'h00, 4,   40'h06,                  8,  8'h00, 8'h00};
        tv[1] = '{C_RDSR,  8'h5A, 4,   40'h0500,                16, 8'h5A, 8'h00};
        tv[2] = '{C_WR,    8'h00, 300, {8'h02, 24'h0, 8'h00},   40, 8'h5A, 8'h00};
        tv[3] = '{C_RD,    8'hC3, 4,   {8'h03, A1, 8'h00},      40, 8'h5A, 8'hC3};
        tv[4] = '{C_WR,    8'h00, 4,   {8'h02, A2, 8'h01},      40, 8'h5A, 8'hC3};
        tv[5] = '{C_RDSR,  8'hA5, 4,   40'h0500,                16, 8'hA5, 8'hC3};
        tv[6] = '{C_RD,    8'h3C, 4,   {8'h03, A3, 8'h00},      40, 8'hA5, 8'h3C};
        tv[7] = '{C_WRITE, 8'hFF, 4,   40'h06,                  8,  8'hA5, 8'h3C};

        #2 rst = 1'b0;
        #10;
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_status", status, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);

        for (int k = 0; k < 8; k++) begin
            start = done_cnt;
            sb.push_back('{tv[k].frame, tv[k].nbits, tv[k].exp_status, tv[k].exp_rd});
            launch(tv[k].cmd, tv[k].resp, tv[k].nbits, tv[k].hold);
            wait_done($sformatf("done_count_%0d", k), start);
        end

        #1;
        check("idle_cs_n", spi_cs_n, 1'b1);
        check("idle_sck", spi_sck, 1'b0);
        check("idle_mosi", spi_mosi, 1'b0);
        check("idle_busy", busy, 1'b0);

        // RD_STATUS edge while WR_DATA is in flight must be dropped.
        start = done_cnt;
        cs0 = cs_falls;
        sb.push_back('{{8'h02, A_END, 8'h02}, 40, 8'hA5, 8'h3C});
        launch(C_WR, 8'h00, 40, 4);
        repeat (20) @(posedge clk);
        #1 controll = C_RDSR;
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1 enable = 1'b0;
        wait_done("busy_edge_done", start);
        repeat (200) @(posedge clk);
        check("busy_edge_done_count", done_cnt, start + 1);
        check("busy_edge_cs_frames", cs_falls, cs0 + 1);

        // Reserved codes launch nothing.
        start = done_cnt;
        cs0 = cs_falls;
        launch(3'b000, 8'h00, 8, 4);
        repeat (60) @(posedge clk);
        check("code000_cs", cs_falls, cs0);
        check("code000_done", done_cnt, start);
        launch(3'b111, 8'h00, 8, 4);
        repeat (60) @(posedge clk);
        check("code111_cs", cs_falls, cs0);
        check("code111_done", done_cnt, start);

        // Reset mid-frame, sampled while SCK is high.
        start = done_cnt;
        launch(C_RD, 8'h99, 40, 4);
        repeat (32) @(posedge clk);
        #1;
        check("midframe_sck_high", spi_sck, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("abort_cs_n", spi_cs_n, 1'b1);
        check("abort_sck", spi_sck, 1'b0);
        check("abort_mosi", spi_mosi, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_status", status, 8'h00);
        check("abort_rd_data", rd_data, 8'h00);

        // Enable held high across reset release must not launch.
        controll = C_WRITE;
        enable = 1'b1;
        cs0 = cs_falls;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (60) @(posedge clk);
        check("abort_no_done", done_cnt, start);
        check("held_enable_no_launch", cs_falls, cs0);
        #1 enable = 1'b0;
        repeat (2) @(posedge clk);

        // wr_data and address restart from zero after reset.
        start = done_cnt;
        sb.push_back('{{8'h02, 24'h0, 8'h00}, 40, 8'h00, 8'h00});
        launch(C_WR, 8'h00, 40, 4);
        wait_done("post_reset_wr_done", start);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
